// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned DEFAULT_PERIOD = 10417;
  localparam int unsigned DATA_BITS      = 8;

  typedef enum logic [2:0] {
    s_IDLE,
    s_START,
    s_DATA,
    s_STOP,
    s_WAIT
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input; resets to 1.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver, LSB first, centre-sampled; one-cycle valid / frame_err strobes.
// Define UART_RECV_MAJORITY_EN to take each sample as a 3-tap majority vote.
module uart_recv
  import uart_pkg::*;
#(
  parameter int unsigned PERIOD = DEFAULT_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(PERIOD);
  localparam logic [CntW-1:0] CntLast = CntW'(PERIOD - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(PERIOD / 2 - 1);
  localparam logic [3:0] IdxLast = 4'(DATA_BITS - 1);

  rx_state_t state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s;
  logic                 sample;

  uart_sync2 u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (serial_in),
    .sync_o  (rx_s)
  );

`ifdef UART_RECV_MAJORITY_EN
  // Counter advances every cycle in the sampling states, so the two history
  // taps line up with counts N-2 and N-1 when the decision is made at N.
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= {hist_q[0], rx_s};
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      s_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = s_START;
      end
      s_START: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sample ? s_IDLE : s_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      s_DATA: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {sample, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxLast) state_d = s_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      s_STOP: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (sample) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = s_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = s_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      s_WAIT: begin
        // Hold off until the line returns high so a break is not a new start.
        cnt_d = '0;
        if (rx_s) state_d = s_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = s_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= s_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != s_IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at PERIOD=16: table of good frames plus corner sequences.
module tb_uart_recv;

  localparam int P = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         t_valid = 0;
  logic [7:0] last_data = 8'h00;

  uart_recv #(.PERIOD(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (valid === 1'b1) begin
        n_valid   = n_valid + 1;
        last_data = data_out;
        t_valid   = cyc;
      end
      if (frame_err === 1'b1) n_ferr = n_ferr + 1;
      if (valid === 1'b1 || frame_err === 1'b1) begin
        checks = checks + 1;
        if (valid === 1'b1 && frame_err === 1'b1) begin
          errors = errors + 1;
          $display("FAIL strobe_exclusive: valid=%b frame_err=%b required not both high",
                   valid, frame_err);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  // Glitch inverts the line for one cycle at the centre of each data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch);
    logic b;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      b = 1'b0;
      else if (i == 9) b = stop;
      else             b = d[i-1];
      for (int j = 0; j < P; j++) begin
        if (glitch && i >= 1 && i <= 8 && j == P / 2) tick(~b);
        else                                          tick(b);
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         gap;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nv0, nf0, t0;
    logic [7:0] exp_maj;

    vecs[0] = '{data: 8'hA5, gap: 20, exp_data: 8'hA5};
    vecs[1] = '{data: 8'h00, gap: 0,  exp_data: 8'h00};
    vecs[2] = '{data: 8'hFF, gap: 20, exp_data: 8'hFF};
    vecs[3] = '{data: 8'h12, gap: 5,  exp_data: 8'h12};
    vecs[4] = '{data: 8'h80, gap: 0,  exp_data: 8'h80};
    vecs[5] = '{data: 8'h01, gap: 20, exp_data: 8'h01};

    rst       = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", {24'h0, data_out}, 32'h0);
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    repeat (5) tick(1'b1);

    // Good frames, including back-to-back ones with no idle gap.
    for (int k = 0; k < 6; k++) begin
      nv0 = n_valid;
      nf0 = n_ferr;
      t0  = cyc;
      send_frame(vecs[k].data, 1'b1, 1'b0);
      if (k == 0) begin
        check("latency_in_range",
              {31'h0, ((t_valid - t0) >= 153 && (t_valid - t0) <= 155)}, 32'h1);
      end
      repeat (vecs[k].gap) tick(1'b1);
      check("vec_valid_count", n_valid - nv0, 1);
      check("vec_ferr_count", n_ferr - nf0, 0);
      check("vec_strobe_data", {24'h0, last_data}, {24'h0, vecs[k].exp_data});
      check("vec_data_out", {24'h0, data_out}, {24'h0, vecs[k].exp_data});
      check("vec_busy_after", {31'h0, busy}, 32'h0);
    end

    // Short low glitch on an idle line is rejected at the start check.
    nv0 = n_valid;
    nf0 = n_ferr;
    repeat (3) tick(1'b0);
    tick(1'b1);
    check("glitch_busy_start", {31'h0, busy}, 32'h1);
    repeat (15) tick(1'b1);
    check("glitch_busy_idle", {31'h0, busy}, 32'h0);
    check("glitch_no_valid", n_valid - nv0, 0);
    check("glitch_no_ferr", n_ferr - nf0, 0);

    // Stop bit low, line held low, then recovery and a good frame.
    nv0 = n_valid;
    nf0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) tick(1'b0);
    check("ferr_count", n_ferr - nf0, 1);
    check("ferr_no_valid", n_valid - nv0, 0);
    check("ferr_data_held", {24'h0, data_out}, 32'h01);
    check("ferr_busy_wait", {31'h0, busy}, 32'h1);
    repeat (20) tick(1'b1);
    check("ferr_busy_released", {31'h0, busy}, 32'h0);
    nv0 = n_valid;
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (10) tick(1'b1);
    check("after_ferr_valid", n_valid - nv0, 1);
    check("after_ferr_data", {24'h0, data_out}, 32'h81);

    // Reset pulse during bit 4 discards the partial byte.
    nv0 = n_valid;
    nf0 = n_ferr;
    repeat (P) tick(1'b0);
    repeat (4 * P + 4) tick(1'b1);
    check("midframe_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    check("midrst_data_out", {24'h0, data_out}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_valid", {31'h0, valid}, 32'h0);
    repeat (6 * P) tick(1'b1);
    check("midrst_no_valid", n_valid - nv0, 0);
    check("midrst_no_ferr", n_ferr - nf0, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (10) tick(1'b1);
    check("post_rst_valid", n_valid - nv0, 1);
    check("post_rst_data", {24'h0, data_out}, 32'h5A);

    // Centre-of-bit glitches: majority voting recovers, single sampling inverts.
`ifdef UART_RECV_MAJORITY_EN
    exp_maj = 8'hC3;
`else
    exp_maj = 8'h3C;
`endif
    nv0 = n_valid;
    send_frame(8'hC3, 1'b1, 1'b1);
    repeat (10) tick(1'b1);
    check("glitch_frame_valid", n_valid - nv0, 1);
    check("glitch_frame_data", {24'h0, data_out}, {24'h0, exp_maj});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
